// File: rtl/fc_pkg.sv
// Shared constants, state type and neuron mapping for the fully-connected layer buffers.
// The neuron mapping is the single source of truth for both fc_obuf drain order and fc_ibuf addressing.
package fc_pkg;

  localparam int DATA_SIZE      = 8;
  localparam int OUTPUT_NEURONS = 128;
  localparam int XBAR_SIZE      = 128;
  localparam int BUS_WIDTH      = 16;
  localparam int ADC_WIDTH      = 8;

  localparam int FIFO_LENGTH = XBAR_SIZE / DATA_SIZE;
  localparam int H_TILES     = OUTPUT_NEURONS / FIFO_LENGTH;
  localparam int NUM_ADDR    = OUTPUT_NEURONS / BUS_WIDTH;
  localparam int ACC_WIDTH   = ADC_WIDTH + DATA_SIZE;
  localparam int ADDR_W      = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } obuf_state_t;

  function automatic int neuron_idx(input int tile, input int slot, input int fifo_len);
    return tile * fifo_len + slot;
  endfunction

endpackage

// File: rtl/fc_obuf_if.sv
// Column-sum write port and next-layer push port of the output buffer.
// Column sums are accepted only while o_ready is high; pushes are held off by i_stall.
interface fc_obuf_if #(
  parameter int DATA_SIZE = fc_pkg::DATA_SIZE,
  parameter int BUS_WIDTH = fc_pkg::BUS_WIDTH,
  parameter int ADC_WIDTH = fc_pkg::ADC_WIDTH,
  parameter int H_TILES   = fc_pkg::H_TILES,
  parameter int ADDR_W    = fc_pkg::ADDR_W
);

  logic                                 i_we;
  logic [ADDR_W-1:0]                    i_addr;
  logic [BUS_WIDTH-1:0][ADC_WIDTH-1:0]  i_data;
  logic                                 i_stall;
  logic                                 o_ready;
  logic                                 o_we;
  logic [H_TILES-1:0][DATA_SIZE-1:0]    o_data;
  logic                                 o_done;

  modport master (
    output i_we, i_addr, i_data, i_stall,
    input  o_ready, o_we, o_data, o_done
  );

  modport slave (
    input  i_we, i_addr, i_data, i_stall,
    output o_ready, o_we, o_data, o_done
  );

endinterface

// File: rtl/fc_requant.sv
// Requantiser: accumulator >> SHIFT, clipped to the largest Q_W-bit value.
// Purely combinational, no flow control.
module fc_requant #(
  parameter int ACC_W = 16,
  parameter int Q_W   = 8,
  parameter int SHIFT = 8
) (
  input  logic [ACC_W-1:0] i_acc,
  output logic [Q_W-1:0]   o_q
);

  localparam logic [ACC_W-1:0] QMAX = ACC_W'((1 << Q_W) - 1);

  logic [ACC_W-1:0] shifted;

  assign shifted = i_acc >> SHIFT;

  always_comb begin
    if (shifted > QMAX) begin
      o_q = '1;
    end else begin
      o_q = shifted[Q_W-1:0];
    end
  end

endmodule

// File: rtl/fc_obuf.sv
// Shift-accumulates bit-serial column sums (LSB plane first), then drains requantised results one slot per push.
// Write-to-acc latency 1 cycle; first push the cycle after the final write; i_stall holds the push and slot counter.
module fc_obuf #(
  parameter int DATA_SIZE      = fc_pkg::DATA_SIZE,
  parameter int OUTPUT_NEURONS = fc_pkg::OUTPUT_NEURONS,
  parameter int XBAR_SIZE      = fc_pkg::XBAR_SIZE,
  parameter int BUS_WIDTH      = fc_pkg::BUS_WIDTH,
  parameter int ADC_WIDTH      = fc_pkg::ADC_WIDTH,
  parameter int SHIFT          = ADC_WIDTH,
  parameter int FIFO_LENGTH    = XBAR_SIZE / DATA_SIZE,
  parameter int H_TILES        = OUTPUT_NEURONS / FIFO_LENGTH,
  parameter int NUM_ADDR       = OUTPUT_NEURONS / BUS_WIDTH,
  parameter int ACC_WIDTH      = ADC_WIDTH + DATA_SIZE
) (
  input  logic      clk,
  input  logic      rst,
  fc_obuf_if.slave  bus
);

  import fc_pkg::obuf_state_t;
  import fc_pkg::ACCUM;
  import fc_pkg::DRAIN;
  import fc_pkg::neuron_idx;

  localparam int PW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int KW = (FIFO_LENGTH > 1) ? $clog2(FIFO_LENGTH) : 1;
  localparam int NW = (OUTPUT_NEURONS > 1) ? $clog2(OUTPUT_NEURONS) : 1;

  obuf_state_t          state_q, state_d;
  logic [PW-1:0]        p_q, p_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 done_q, done_d;
  logic [ACC_WIDTH-1:0] acc_q [OUTPUT_NEURONS];
  logic [ACC_WIDTH-1:0] acc_d [OUTPUT_NEURONS];

  logic                 wr_en;
  logic                 push;
  logic                 last_push;
  logic [ACC_WIDTH-1:0] sel_acc [H_TILES];
  logic [H_TILES-1:0][DATA_SIZE-1:0] q_vec;

  assign wr_en     = (state_q == ACCUM) && bus.i_we && (int'(bus.i_addr) < NUM_ADDR);
  assign push      = (state_q == DRAIN) && !bus.i_stall;
  assign last_push = push && (k_q == KW'(FIFO_LENGTH - 1));

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    k_d     = k_q;
    done_d  = 1'b0;
    acc_d   = acc_q;

    if (wr_en) begin
      for (int a = 0; a < NUM_ADDR; a++) begin
        if (int'(bus.i_addr) == a) begin
          for (int l = 0; l < BUS_WIDTH; l++) begin
            acc_d[a*BUS_WIDTH + l] = acc_q[a*BUS_WIDTH + l]
                                   + (ACC_WIDTH'(bus.i_data[l]) << p_q);
          end
        end
      end
      // The last lane group closes a plane; the last plane closes the frame.
      if (int'(bus.i_addr) == NUM_ADDR - 1) begin
        if (p_q == PW'(DATA_SIZE - 1)) begin
          state_d = DRAIN;
        end else begin
          p_d = p_q + 1'b1;
        end
      end
    end

    if (push) begin
      k_d = k_q + 1'b1;
    end

    if (last_push) begin
      state_d = ACCUM;
      p_d     = '0;
      k_d     = '0;
      done_d  = 1'b1;
      for (int n = 0; n < OUTPUT_NEURONS; n++) begin
        acc_d[n] = '0;
      end
    end
  end

  // Highest slot goes first so it ends up deepest in the downstream shift FIFO.
  always_comb begin
    for (int j = 0; j < H_TILES; j++) begin
      sel_acc[j] = acc_q[NW'(neuron_idx(j, FIFO_LENGTH - 1 - int'(k_q), FIFO_LENGTH))];
    end
  end

  for (genvar j = 0; j < H_TILES; j++) begin : g_rq
    fc_requant #(
      .ACC_W (ACC_WIDTH),
      .Q_W   (DATA_SIZE),
      .SHIFT (SHIFT)
    ) u_requant (
      .i_acc (sel_acc[j]),
      .o_q   (q_vec[j])
    );
  end

  assign bus.o_data  = q_vec;
  assign bus.o_ready = (state_q == ACCUM);
  assign bus.o_we    = push;
  assign bus.o_done  = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      p_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      for (int n = 0; n < OUTPUT_NEURONS; n++) begin
        acc_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      k_q     <= k_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_fc_obuf.sv
// Directed bench for fc_obuf: default SHIFT instance plus a SHIFT=4 instance sharing the same stimulus.
module tb_fc_obuf;
  import fc_pkg::*;

  typedef logic [H_TILES-1:0][DATA_SIZE-1:0] ovec_t;

  localparam int M_ZERO   = 0;
  localparam int M_FULL   = 1;
  localparam int M_SINGLE = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  fc_obuf_if ifa ();
  fc_obuf_if ifb ();

  assign ifb.i_we    = ifa.i_we;
  assign ifb.i_addr  = ifa.i_addr;
  assign ifb.i_data  = ifa.i_data;
  assign ifb.i_stall = ifa.i_stall;

  fc_obuf u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  fc_obuf #(.SHIFT(4)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  // Hand-derived outputs: full scale acc=255*255=65025 -> 254 (>>8) / 255 clipped (>>4);
  // single neuron 5 acc=4<<7=512 -> 2 (>>8) / 32 (>>4), pushed at slot 15-5=10 on tile 0.
  function automatic ovec_t exp_vec(input int mode, input int k, input bit sat);
    ovec_t v;
    v = '0;
    for (int j = 0; j < H_TILES; j++) begin
      if (mode == M_FULL) v[j] = sat ? 8'd255 : 8'd254;
      else if (mode == M_SINGLE && j == 0 && k == 10) v[j] = sat ? 8'd32 : 8'd2;
    end
    return v;
  endfunction

  task automatic send_frame(input int mode, input int planes, input string name);
    n_total++;
    if (ifa.o_ready !== 1'b1) $display("FAIL %s ready_before_frame got %b want 1", name, ifa.o_ready);
    else n_pass++;
    for (int p = 0; p < planes; p++) begin
      for (int a = 0; a < NUM_ADDR; a++) begin
        ifa.i_data = '0;
        if (mode == M_FULL) ifa.i_data = '1;
        if (mode == M_SINGLE && p == DATA_SIZE - 1 && a == 0) ifa.i_data[5] = 8'd4;
        ifa.i_addr = ADDR_W'(a);
        ifa.i_we   = 1'b1;
        @(posedge clk); #1;
      end
    end
    ifa.i_we   = 1'b0;
    ifa.i_data = '0;
  endtask

  task automatic drain_check(input int mode, input int st_lo, input int st_hi,
                             input bit we_in_drain, input string name);
    int    pushes = 0;
    int    cyc    = 0;
    ovec_t prev_a, prev_b, ea, eb;
    prev_a = '0;
    prev_b = '0;
    while (pushes < FIFO_LENGTH && cyc < 40) begin
      ifa.i_stall = (cyc >= st_lo && cyc <= st_hi);
      ifa.i_we    = we_in_drain && (cyc < 8);
      ifa.i_addr  = '0;
      ifa.i_data  = '1;
      #1;
      if (ifa.i_stall) begin
        n_total++;
        if (ifa.o_we !== 1'b0 || ifb.o_we !== 1'b0)
          $display("FAIL %s stall_we cyc %0d got %b/%b want 0/0", name, cyc, ifa.o_we, ifb.o_we);
        else n_pass++;
        n_total++;
        if (ifa.o_data !== prev_a || ifb.o_data !== prev_b)
          $display("FAIL %s stall_hold cyc %0d got %h/%h want %h/%h", name, cyc,
                   ifa.o_data, ifb.o_data, prev_a, prev_b);
        else n_pass++;
      end else begin
        ea = exp_vec(mode, pushes, 1'b0);
        eb = exp_vec(mode, pushes, 1'b1);
        n_total++;
        if (ifa.o_we !== 1'b1 || ifb.o_we !== 1'b1)
          $display("FAIL %s push_we k %0d got %b/%b want 1/1", name, pushes, ifa.o_we, ifb.o_we);
        else n_pass++;
        n_total++;
        if (ifa.o_data !== ea) $display("FAIL %s data k %0d got %h want %h", name, pushes, ifa.o_data, ea);
        else n_pass++;
        n_total++;
        if (ifb.o_data !== eb) $display("FAIL %s sat_data k %0d got %h want %h", name, pushes, ifb.o_data, eb);
        else n_pass++;
        pushes++;
      end
      prev_a = ifa.o_data;
      prev_b = ifb.o_data;
      @(posedge clk); #1;
      cyc++;
    end
    ifa.i_stall = 1'b0;
    ifa.i_we    = 1'b0;
    ifa.i_data  = '0;
    n_total++;
    if (pushes !== FIFO_LENGTH) $display("FAIL %s push_count got %0d want %0d", name, pushes, FIFO_LENGTH);
    else n_pass++;
    n_total++;
    if (ifa.o_done !== 1'b1 || ifb.o_done !== 1'b1)
      $display("FAIL %s done_pulse got %b/%b want 1/1", name, ifa.o_done, ifb.o_done);
    else n_pass++;
    n_total++;
    if (ifa.o_ready !== 1'b1 || ifa.o_we !== 1'b0)
      $display("FAIL %s ready_after got ready=%b we=%b want 1/0", name, ifa.o_ready, ifa.o_we);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (ifa.o_done !== 1'b0) $display("FAIL %s done_width got %b want 0", name, ifa.o_done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    ifa.i_we    = 1'b0;
    ifa.i_addr  = '0;
    ifa.i_data  = '0;
    ifa.i_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_total++;
    if (ifa.o_ready !== 1'b1 || ifb.o_ready !== 1'b1)
      $display("FAIL reset_ready got %b/%b want 1/1", ifa.o_ready, ifb.o_ready);
    else n_pass++;
    n_total++;
    if (ifa.o_we !== 1'b0 || ifa.o_done !== 1'b0)
      $display("FAIL reset_we_done got %b/%b want 0/0", ifa.o_we, ifa.o_done);
    else n_pass++;
    n_total++;
    if (ifa.o_data !== '0 || ifb.o_data !== '0)
      $display("FAIL reset_data got %h/%h want 0", ifa.o_data, ifb.o_data);
    else n_pass++;
  endtask

  task automatic test_full_scale();
    send_frame(M_FULL, DATA_SIZE, "full");
    n_total++;
    if (ifa.o_ready !== 1'b0) $display("FAIL full ready_in_drain got %b want 0", ifa.o_ready);
    else n_pass++;
    drain_check(M_FULL, -1, -1, 1'b0, "full");
  endtask

  task automatic test_single_neuron();
    send_frame(M_SINGLE, DATA_SIZE, "single");
    drain_check(M_SINGLE, -1, -1, 1'b0, "single");
  endtask

  task automatic test_stall_ignore();
    send_frame(M_SINGLE, DATA_SIZE, "stall");
    drain_check(M_SINGLE, 3, 5, 1'b1, "stall");
  endtask

  task automatic test_back_to_back();
    send_frame(M_SINGLE, DATA_SIZE, "b2b");
    drain_check(M_SINGLE, -1, -1, 1'b0, "b2b");
  endtask

  task automatic test_mid_frame_reset();
    send_frame(M_FULL, 3, "abort");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++;
    if (ifa.o_ready !== 1'b1 || ifa.o_done !== 1'b0 || ifa.o_data !== '0)
      $display("FAIL abort_state got ready=%b done=%b data=%h want 1/0/0", ifa.o_ready, ifa.o_done, ifa.o_data);
    else n_pass++;
    send_frame(M_SINGLE, DATA_SIZE, "after_abort");
    drain_check(M_SINGLE, -1, -1, 1'b0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_single_neuron();
    test_stall_ignore();
    test_back_to_back();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/fc_obuf.md
# fc_obuf

Output buffer for a fully-connected layer. It collects the bit-serial crossbar column sums of the current layer, one input bit plane at a time, LSB first, and shift-accumulates them into per-neuron accumulators. After the last plane it requantises each accumulator to DATA_SIZE bits and pushes the results into the next layer's input buffer. Each push carries one element per next-layer CIM tile, filling the input buffer's per-tile FIFOs.

## Interface
Parameters:
- DATA_SIZE, 8, activation width; also the number of bit planes per frame
- OUTPUT_NEURONS, 128, neurons produced by this layer
- XBAR_SIZE, 128, crossbar rows
- BUS_WIDTH, 16, column-sum lanes per write
- ADC_WIDTH, 8, width of one column sum
- SHIFT, ADC_WIDTH, right shift applied at requantisation
- FIFO_LENGTH, XBAR_SIZE/DATA_SIZE (16), elements per next-layer tile
- H_TILES, OUTPUT_NEURONS/FIFO_LENGTH (8), next-layer tiles
- NUM_ADDR, OUTPUT_NEURONS/BUS_WIDTH (8), write addresses per plane
- ACC_WIDTH, ADC_WIDTH+DATA_SIZE (16), accumulator width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_we  in  1  column-sum write strobe
- i_addr  in  $clog2(NUM_ADDR)  lane group; neurons i_addr*BUS_WIDTH+l
- i_data  in  [ADC_WIDTH-1:0] x BUS_WIDTH  column sums, lane l
- i_stall  in  1  downstream hold; suppresses push this cycle
- o_ready  out  1  high in ACCUM; writes accepted only when high
- o_we  out  1  push strobe to next input buffer
- o_data  out  [DATA_SIZE-1:0] x H_TILES  one element per next-layer tile
- o_done  out  1  one-cycle pulse after final push of a frame

## Operation
- States: ACCUM, DRAIN. Reset enters ACCUM with all accumulators, plane counter p and slot counter k zeroed.
- ACCUM:
  - On i_we && i_addr < NUM_ADDR: acc[i_addr*BUS_WIDTH+l] += i_data[l] << p, for every lane l.
  - Writes with i_addr >= NUM_ADDR are ignored.
  - A write to i_addr == NUM_ADDR-1 advances p. When p == DATA_SIZE-1, that write moves the block to DRAIN instead.
  - Repeated or out-of-order addresses within a plane simply accumulate again. No error flag.
- Arithmetic is unsigned. The accumulator cannot overflow: (2^ADC_WIDTH-1)*(2^DATA_SIZE-1) < 2^ACC_WIDTH.
- Requantisation: q = acc >> SHIFT, saturated to 2^DATA_SIZE-1.
- DRAIN:
  - o_we = !i_stall.
  - o_data[j] = q(neuron j*FIFO_LENGTH + FIFO_LENGTH-1-k). The last slot is pushed first, so it lands deepest in the downstream shift FIFO.
  - k increments on each push.
  - On the push with k == FIFO_LENGTH-1: return to ACCUM, clear accumulators, p and k. o_done pulses the following cycle.
- i_we during DRAIN is ignored (o_ready=0).

## Timing
- Reset values: o_ready=1, o_we=0, o_done=0, o_data=0 (accumulators zero).
- o_ready and o_we are decoded from state, so they are combinational from registers.
- o_data is combinational from acc and k.
- Accumulate latency: one cycle; a write at cycle t is reflected in acc at t+1.
- Drain latency: final plane write at cycle t gives the first push at t+1 (absent stall).
- An unstalled drain is FIFO_LENGTH consecutive cycles. o_done is at t+FIFO_LENGTH+1. o_ready=1 from t+FIFO_LENGTH+1, the same cycle as o_done.
- i_stall high: no push and k holds, so o_data stays stable. Release resumes at the same k.
- rst mid-frame or mid-drain aborts the frame and returns to the reset state next cycle; no o_done.

## Structure
- Package fc_pkg holds:
  - the derived constants FIFO_LENGTH, H_TILES, NUM_ADDR, ACC_WIDTH
  - typedef obuf_state_t {ACCUM, DRAIN}
  - a neuron-index function (tile, slot) -> neuron, shared with fc_ibuf address mapping
- Sub-module fc_requant: combinational shift-and-saturate, ACC_WIDTH -> DATA_SIZE, instantiated H_TILES times on the drain mux outputs.

## Test plan
- Reset: assert rst 2 cycles -> o_ready=1, o_we=0, o_done=0, o_data all 0.
- Full-scale frame: all lanes 255 on every address, 8 planes -> acc=65025, q=254. 16 consecutive pushes, all elements 254. o_done 17 cycles after the last write.
- Single neuron: neuron 5 gets sum 4 on plane 7 only, all else 0 -> acc=512, q=2. The element appears on push k=10, tile 0; every other element is 0.
- Saturation: SHIFT=4 with the full-scale frame -> q clips to 255 everywhere.
- Stall and ignore: hold i_stall during drain cycles 3-5, and issue i_we during drain -> o_data held and no o_we in those cycles; exactly 16 pushes with correct values. The next frame starts from zero accumulators, unaffected by the drain-time writes.
- Mid-frame reset: rst after 3 planes, then a full single-neuron frame -> output identical to the single-neuron case.
